fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Front-end stage of the 5-stage RV64 pipeline. It produces the fetch-to-decode record (raw_instr, pc, is_bubble) that the decode stage consumes.
- Issues one instruction-bus request at a time and advances the PC sequentially by 4.
- Takes branch/jump redirects from decode (taken flag, branch PC, offset) and squashes the wrong-path fetch.
- Holds its output register while downstream stalls.

Parameters:
- PC_RESET, 64'h0000_0000_8000_0000, PC loaded on reset.
- XLEN, 64, PC/offset width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- ireq_valid  out  1  instruction fetch request.
- ireq_addr  out  XLEN  fetch address; stable while ireq_valid=1 until iresp_data_ok.
- iresp_data_ok  in  1  response strobe; may rise in the same cycle ireq_valid first rises.
- iresp_data  in  32  instruction word, valid with iresp_data_ok.
- stall  in  1  decode not accepting; output register must hold.
- redirect_valid  in  1  decode resolved a taken branch or JAL.
- redirect_pc  in  XLEN  PC of the branch instruction.
- redirect_offset  in  XLEN  sign-extended offset.
- out_raw_instr  out  32  to decode.
- out_pc  out  XLEN  to decode.
- out_is_bubble  out  1  1 = slot carries no instruction.

Behaviour:
- State register: S_FETCH (request outstanding, result kept), S_DROP (request outstanding, result to be discarded), S_HOLD (word buffered, waiting for stall to clear).
- Reset (async, takes effect immediately):
  - state=S_FETCH, pc=PC_RESET.
  - out_is_bubble=1, out_pc=0, out_raw_instr=0.
  - ireq_valid=0 while reset is asserted.
- ireq_valid=1 in S_FETCH and S_DROP; 0 in S_HOLD. ireq_addr=pc.
- Bus rule: an outstanding request is never withdrawn or changed before data_ok.
- target = redirect_pc + redirect_offset, 64-bit modular add, no alignment check.
- redirect_valid is ignored while stall=1; decode re-asserts it.
- S_FETCH, data_ok=1, stall=0, no redirect:
  - out <= {iresp_data, pc, bubble=0}; pc <= pc+4 (wraps mod 2^64); stay in S_FETCH.
  - With a zero-wait bus this gives one instruction per cycle; latency from request to output is one edge.
- S_FETCH, data_ok=1, stall=1:
  - Buffer the word and its pc; output held; go to S_HOLD.
- S_FETCH, data_ok=0, stall=0:
  - out_is_bubble <= 1 (out_pc and out_raw_instr don't-care, keep their values).
- S_FETCH, redirect_valid=1, stall=0, data_ok=1 in the same cycle:
  - Discard the word; pc <= target; out bubble; stay in S_FETCH, so the next request uses target.
- S_FETCH, redirect_valid=1, stall=0, data_ok=0:
  - pc <= target; out bubble; go to S_DROP.
  - ireq_addr stays at the old address until data_ok. It is driven from a separate req_addr register, latched when a request launches.
- S_DROP:
  - A further redirect overwrites pc (latest wins).
  - On data_ok: discard the word, out bubble, go to S_FETCH.
  - Output register gets a bubble each non-stalled cycle.
- S_HOLD:
  - While stall=1, everything is held.
  - stall=0, no redirect: out <= buffered word and pc, bubble=0; pc <= pc+4; go to S_FETCH.
  - stall=0 with redirect: drop the buffer; out bubble; pc <= target; go to S_FETCH.
- Stalled cycles never modify out_* in any state.
- Reset asserted mid-request: the in-flight request is abandoned. The bus is required to tolerate the loss of ireq_valid on reset.

Test Plan:
- Reset, then zero-wait bus (data_ok same cycle), stall=0 → out_pc sequence 0x8000_0000, 0x8000_0004, 0x8000_0008 on consecutive edges, bubble=0, out_raw_instr matches memory words.
- Bus with 3-cycle latency → two bubble cycles between instructions; ireq_addr held constant for all 3 cycles.
- Assert stall while data_ok returns word 0x00A00093 at pc 0x8000_0004, hold stall 4 cycles → out unchanged and ireq_valid=0 during the stall. On release, out={0x00A00093, 0x8000_0004, 0}; next request is 0x8000_0008.
- redirect_valid with redirect_pc=0x8000_0010, offset=-8, while a 2-cycle request is pending → in-flight word discarded with no bubble=0 output for it; next ireq_addr=0x8000_0008.
- Redirect in the same cycle as data_ok → word dropped; next cycle ireq_addr=target. Redirect with stall=1 → ignored, pc unchanged.
- Assert reset mid-request at pc 0x8000_0020 → outputs immediately reset (bubble=1); after release, first ireq_addr=PC_RESET.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding bus request at a time, sequential PC,
// redirect squashing of wrong-path fetches, and an output register that holds under stall.
module fetch_stage #(
    parameter int unsigned          XLEN     = 64,
    parameter logic [XLEN-1:0]      PC_RESET = 64'h0000_0000_8000_0000
) (
    input  logic            clk,
    input  logic            reset,
    output logic            ireq_valid,
    output logic [XLEN-1:0] ireq_addr,
    input  logic            iresp_data_ok,
    input  logic [31:0]     iresp_data,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic [XLEN-1:0] redirect_offset,
    output logic [31:0]     out_raw_instr,
    output logic [XLEN-1:0] out_pc,
    output logic            out_is_bubble
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_DROP  = 2'd1,
        S_HOLD  = 2'd2
    } state_e;

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;
    logic [31:0]     buf_instr_q, buf_instr_d;
    logic [XLEN-1:0] buf_pc_q, buf_pc_d;
    logic [31:0]     out_instr_q, out_instr_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d;
    logic            out_bub_q, out_bub_d;

    logic [XLEN-1:0] target_s;
    logic            redir_s;

    assign target_s = redirect_pc + redirect_offset;
    assign redir_s  = redirect_valid & ~stall;

    // Bus address comes from req_addr_q so a redirect never disturbs an outstanding request.
    assign ireq_valid    = ~reset & (state_q != S_HOLD);
    assign ireq_addr     = req_addr_q;
    assign out_raw_instr = out_instr_q;
    assign out_pc        = out_pc_q;
    assign out_is_bubble = out_bub_q;

    // Next-state, PC and output-register update logic.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_addr_d  = req_addr_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;
        out_bub_d   = out_bub_q;

        case (state_q)
            S_FETCH: begin
                if (redir_s) begin
                    pc_d      = target_s;
                    out_bub_d = 1'b1;
                    if (iresp_data_ok) begin
                        req_addr_d = target_s;
                    end else begin
                        state_d = S_DROP;
                    end
                end else if (iresp_data_ok) begin
                    if (stall) begin
                        buf_instr_d = iresp_data;
                        buf_pc_d    = pc_q;
                        state_d     = S_HOLD;
                    end else begin
                        out_instr_d = iresp_data;
                        out_pc_d    = pc_q;
                        out_bub_d   = 1'b0;
                        pc_d        = pc_q + PC_STEP;
                        req_addr_d  = pc_q + PC_STEP;
                    end
                end else if (!stall) begin
                    out_bub_d = 1'b1;
                end else begin
                    out_bub_d = out_bub_q;
                end
            end
            S_DROP: begin
                if (!stall) begin
                    out_bub_d = 1'b1;
                end else begin
                    out_bub_d = out_bub_q;
                end
                if (redir_s) begin
                    pc_d = target_s;
                end else begin
                    pc_d = pc_q;
                end
                // The squashed word is simply not captured; the next request uses the latest pc.
                if (iresp_data_ok) begin
                    state_d    = S_FETCH;
                    req_addr_d = redir_s ? target_s : pc_q;
                end else begin
                    state_d = S_DROP;
                end
            end
            S_HOLD: begin
                if (!stall) begin
                    state_d = S_FETCH;
                    if (redirect_valid) begin
                        pc_d       = target_s;
                        req_addr_d = target_s;
                        out_bub_d  = 1'b1;
                    end else begin
                        out_instr_d = buf_instr_q;
                        out_pc_d    = buf_pc_q;
                        out_bub_d   = 1'b0;
                        pc_d        = buf_pc_q + PC_STEP;
                        req_addr_d  = buf_pc_q + PC_STEP;
                    end
                end else begin
                    state_d = S_HOLD;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // State, PC, request address, buffer and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_FETCH;
            pc_q        <= PC_RESET;
            req_addr_q  <= PC_RESET;
            buf_instr_q <= 32'h0000_0000;
            buf_pc_q    <= {XLEN{1'b0}};
            out_instr_q <= 32'h0000_0000;
            out_pc_q    <= {XLEN{1'b0}};
            out_bub_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_addr_q  <= req_addr_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
            out_bub_q   <= out_bub_d;
        end
    end

endmodule
